// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store sequencer for the single-port, read-registered data memory
// One request at a time; single or double word; one-cycle response pulse with wrap flag.
module lsu_mem_ctrl #(
   parameter int DATA = 16,
   parameter int ADDR = 12
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic                req_dbl_i,
   input  logic [ADDR-1:0]     req_addr_i,
   input  logic [2*DATA-1:0]   req_wdata_i,
   output logic                rsp_valid_o,
   output logic [2*DATA-1:0]   rsp_rdata_o,
   output logic                rsp_err_o,
   output logic                mem_we_o,
   output logic [ADDR-1:0]     mem_addr_o,
   output logic [DATA-1:0]     mem_wdata_o,
   input  logic [DATA-1:0]     mem_rdata_i
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACC_LO = 3'd1,
      ACC_HI = 3'd2,
      CAP_LO = 3'd3,
      CAP_HI = 3'd4
   } state_e;

   localparam logic [ADDR-1:0] ADDR_ONE = {{(ADDR-1){1'b0}}, 1'b1};

   state_e            state_q;
   logic              we_q;
   logic              dbl_q;
   logic              wrap_q;
   logic [DATA-1:0]   wdata_hi_q;
   logic              rsp_valid_q;
   logic [2*DATA-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              mem_we_q;
   logic [ADDR-1:0]   mem_addr_q;
   logic [DATA-1:0]   mem_wdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         dbl_q       <= 1'b0;
         wrap_q      <= 1'b0;
         wdata_hi_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  we_q        <= req_we_i;
                  dbl_q       <= req_dbl_i;
                  wrap_q      <= req_dbl_i && (req_addr_i == '1);
                  wdata_hi_q  <= req_wdata_i[2*DATA-1:DATA];
                  mem_addr_q  <= req_addr_i;
                  mem_we_q    <= req_we_i;
                  mem_wdata_q <= req_wdata_i[DATA-1:0];
                  state_q     <= ACC_LO;
               end
            end
            ACC_LO: begin
               if (dbl_q) begin
                  // Address increment wraps modulo 2^ADDR; wrap_q already flags it.
                  mem_addr_q  <= mem_addr_q + ADDR_ONE;
                  mem_wdata_q <= wdata_hi_q;
                  mem_we_q    <= we_q;
                  state_q     <= ACC_HI;
               end else begin
                  mem_we_q <= 1'b0;
                  if (we_q) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     state_q <= CAP_LO;
                  end
               end
            end
            ACC_HI: begin
               mem_we_q <= 1'b0;
               if (we_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= wrap_q;
                  state_q     <= IDLE;
               end else begin
                  rsp_rdata_q[DATA-1:0] <= mem_rdata_i;
                  state_q               <= CAP_HI;
               end
            end
            CAP_LO: begin
               rsp_rdata_q <= {{DATA{1'b0}}, mem_rdata_i};
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               state_q     <= IDLE;
            end
            CAP_HI: begin
               rsp_rdata_q[2*DATA-1:DATA] <= mem_rdata_i;
               rsp_valid_q                <= 1'b1;
               rsp_err_q                  <= wrap_q;
               state_q                    <= IDLE;
            end
            default: begin
               mem_we_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
// Transaction-level reference memory predicts load data, latency, wrap flag and write counts.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_dbl;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   logic [15:0] mem     [0:4095];
   logic [15:0] ref_mem [0:4095];
   logic [31:0] exp_rdata;
   int tests = 0;
   int fails = 0;
   int we_cnt = 0;
   int bad_we = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_dbl_i   (req_dbl),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   // Single-port data memory with registered read, no reset.
   always @(posedge clk) begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   always @(negedge clk) begin
      if (mem_we === 1'b1) we_cnt++;
      if (mem_we === 1'b1 && req_ready === 1'b1) bad_we++;
   end

   task automatic scramble_inputs();
      req_we    = 1'($urandom);
      req_dbl   = 1'($urandom);
      req_addr  = 12'($urandom);
      req_wdata = $urandom;
   endtask

   task automatic run_req(input logic we, input logic dbl, input logic [11:0] a, input logic [31:0] wd);
      int cyc;
      int lat;
      logic [31:0] exp;
      logic        err;
      logic [11:0] a1;
      a1  = a + 12'd1;
      lat = 2 + (dbl ? 1 : 0) + (we ? 0 : 1);
      err = dbl && (a == 12'hFFF);
      if (we) exp = exp_rdata;
      else if (dbl) exp = {ref_mem[a1], ref_mem[a]};
      else exp = {16'h0000, ref_mem[a]};
      @(negedge clk);
      cyc = 0;
      while (req_ready !== 1'b1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      tests++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL req_ready_idle got=%b want=1", req_ready);
      end
      req_we = we; req_dbl = dbl; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      scramble_inputs();
      we_cnt = 0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (rsp_valid !== 1'b1 && cyc < 12);
      tests++;
      if (cyc !== lat) begin
         fails++;
         $display("FAIL latency we=%b dbl=%b a=%h got=%0d want=%0d", we, dbl, a, cyc, lat);
      end
      tests++;
      if (rsp_rdata !== exp) begin
         fails++;
         $display("FAIL rsp_rdata we=%b dbl=%b a=%h got=%h want=%h", we, dbl, a, rsp_rdata, exp);
      end
      tests++;
      if (rsp_err !== err) begin
         fails++;
         $display("FAIL rsp_err a=%h dbl=%b got=%b want=%b", a, dbl, rsp_err, err);
      end
      tests++;
      if (we_cnt !== (we ? (dbl ? 2 : 1) : 0)) begin
         fails++;
         $display("FAIL mem_we_cycles we=%b dbl=%b got=%0d", we, dbl, we_cnt);
      end
      if (we) begin
         ref_mem[a] = wd[15:0];
         if (dbl) ref_mem[a1] = wd[31:16];
      end else begin
         exp_rdata = exp;
      end
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL rsp_one_cycle got=%b want=0", rsp_valid);
      end
      if (we) begin
         tests++;
         if (mem[a] !== ref_mem[a] || mem[a1] !== ref_mem[a1]) begin
            fails++;
            $display("FAIL mem_contents a=%h got=%h_%h want=%h_%h", a, mem[a1], mem[a], ref_mem[a1], ref_mem[a]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b1;
      scramble_inputs();
      we_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000 || rsp_rdata !== 32'h0
          || mem_addr !== 12'h0 || mem_wdata !== 16'h0) begin
         fails++;
         $display("FAIL reset_values got rdy=%b rv=%b err=%b we=%b rd=%h ma=%h wd=%h want 1 0 0 0 0 0 0",
                  req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
      end
      rst = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || we_cnt !== 0) begin
         fails++;
         $display("FAIL reset_no_accept got rdy=%b rv=%b we_cycles=%0d want 1 0 0", req_ready, rsp_valid, we_cnt);
      end
      exp_rdata = 32'h0;
   endtask

   task automatic test_single();
      run_req(1'b1, 1'b0, 12'h010, 32'h0000_BEEF);
      run_req(1'b0, 1'b0, 12'h010, 32'h0);
   endtask

   task automatic test_double();
      run_req(1'b1, 1'b1, 12'h020, 32'h1234_5678);
      tests++;
      if (mem[12'h020] !== 16'h5678 || mem[12'h021] !== 16'h1234) begin
         fails++;
         $display("FAIL dbl_store_mem got=%h_%h want=1234_5678", mem[12'h021], mem[12'h020]);
      end
      run_req(1'b0, 1'b1, 12'h020, 32'h0);
   endtask

   task automatic test_wrap();
      run_req(1'b1, 1'b1, 12'hFFF, 32'hAAAA_5555);
      tests++;
      if (mem[12'hFFF] !== 16'h5555 || mem[12'h000] !== 16'hAAAA) begin
         fails++;
         $display("FAIL wrap_mem got=%h_%h want=aaaa_5555", mem[12'h000], mem[12'hFFF]);
      end
      run_req(1'b0, 1'b1, 12'hFFF, 32'h0);
      run_req(1'b0, 1'b0, 12'h000, 32'h0);
   endtask

   task automatic test_random();
      logic [11:0] a;
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'h300 + 12'($urandom_range(0, 15));
         run_req(1'($urandom), 1'($urandom), a, $urandom);
      end
   endtask

   task automatic test_back_to_back();
      logic        we_l  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic        dbl_l [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [11:0] a_l   [4] = '{12'h400, 12'h400, 12'h402, 12'h402};
      logic [31:0] wd_l  [4];
      logic [31:0] exp;
      logic [11:0] a1;
      int cyc;
      int lat;
      wd_l[0] = $urandom; wd_l[1] = $urandom; wd_l[2] = $urandom; wd_l[3] = $urandom;
      bad_we = 0;
      @(negedge clk);
      req_we = we_l[0]; req_dbl = dbl_l[0]; req_addr = a_l[0]; req_wdata = wd_l[0]; req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a1  = a_l[i] + 12'd1;
         lat = 2 + (dbl_l[i] ? 1 : 0) + (we_l[i] ? 0 : 1);
         if (we_l[i]) exp = exp_rdata;
         else if (dbl_l[i]) exp = {ref_mem[a1], ref_mem[a_l[i]]};
         else exp = {16'h0000, ref_mem[a_l[i]]};
         @(posedge clk);
         #1;
         we_cnt = 0;
         if (i < 3) begin
            req_we = we_l[i+1]; req_dbl = dbl_l[i+1]; req_addr = a_l[i+1]; req_wdata = wd_l[i+1];
         end else begin
            req_valid = 1'b0;
         end
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (rsp_valid !== 1'b1 && cyc < 12);
         tests++;
         if (cyc !== lat || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_latency idx=%0d got=%0d rdy=%b want=%0d rdy=1", i, cyc, req_ready, lat);
         end
         tests++;
         if (rsp_rdata !== exp || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL b2b_rdata idx=%0d got=%h err=%b want=%h err=0", i, rsp_rdata, rsp_err, exp);
         end
         tests++;
         if (we_cnt !== (we_l[i] ? (dbl_l[i] ? 2 : 1) : 0)) begin
            fails++;
            $display("FAIL b2b_we_cycles idx=%0d got=%0d", i, we_cnt);
         end
         if (we_l[i]) begin
            ref_mem[a_l[i]] = wd_l[i][15:0];
            if (dbl_l[i]) ref_mem[a1] = wd_l[i][31:16];
         end else begin
            exp_rdata = exp;
         end
      end
      @(negedge clk);
      tests++;
      if (bad_we !== 0 || rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_we_in_idle got=%0d rv=%b want=0 0", bad_we, rsp_valid);
      end
   endtask

   // rst_cycle 1 lands reset in ACC_LO, 2 lands it in ACC_HI.
   task automatic test_reset_mid(input int rst_cycle, input logic [11:0] a);
      logic [31:0] wd;
      logic [11:0] a1;
      logic [15:0] exp_hi;
      int bad;
      wd = $urandom;
      a1 = a + 12'd1;
      exp_hi = (rst_cycle == 2) ? wd[31:16] : ref_mem[a1];
      @(negedge clk);
      req_we = 1'b1; req_dbl = 1'b1; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (rst_cycle == 2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL rst_mid_idle cyc=%0d bad_cycles got=%0d want=0", rst_cycle, bad);
      end
      ref_mem[a]  = wd[15:0];
      ref_mem[a1] = exp_hi;
      tests++;
      if (mem[a] !== wd[15:0] || mem[a1] !== exp_hi) begin
         fails++;
         $display("FAIL rst_mid_mem cyc=%0d got=%h_%h want=%h_%h", rst_cycle, mem[a1], mem[a], exp_hi, wd[15:0]);
      end
      tests++;
      if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_rsp got=%h err=%b want=0 0", rsp_rdata, rsp_err);
      end
      exp_rdata = 32'h0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i]     = 16'h0;
         ref_mem[i] = 16'h0;
      end
      exp_rdata = 32'h0;
      rst = 1'b1;
      req_valid = 1'b0;
      scramble_inputs();
      test_reset();
      test_single();
      test_double();
      test_wrap();
      test_random();
      test_back_to_back();
      test_reset_mid(2, 12'h500);
      test_reset_mid(1, 12'h510);
      run_req(1'b0, 1'b1, 12'h500, 32'h0);
      run_req(1'b0, 1'b1, 12'h510, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller that sits directly upstream of the data memory in the 16-bit CPU. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and sequences the single-port, read-registered data memory. It supports single-word (16-bit) and double-word (32-bit, two consecutive addresses) transfers, and returns a one-cycle response pulse carrying load data and an address-wrap flag.

## Interface
- DATA, 16, memory word width
- ADDR, 12, word-address width; memory depth 2^ADDR
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high exactly when state = IDLE
- req_we  in  1  1 = store, 0 = load
- req_dbl  in  1  1 = double word (addresses A, A+1), 0 = single word
- req_addr  in  ADDR  word address A
- req_wdata  in  2*DATA  store data; [DATA-1:0] → A, [2*DATA-1:DATA] → A+1
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  2*DATA  load data; upper half 0 for single; holds value between pulses
- rsp_err  out  1  valid with rsp_valid; 1 when a double access wrapped from 2^ADDR-1 to 0
- mem_we  out  1  memory write enable (1 write, 0 read), registered
- mem_addr  out  ADDR  memory address, registered; zero-extended at top level to the memory address port
- mem_wdata  out  DATA  memory write data, registered
- mem_rdata  in  DATA  memory read data; valid the cycle after a read address is presented

## Operation
- States: IDLE, ACC_LO, ACC_HI, CAP_LO, CAP_HI.
- Accept: req_valid & req_ready at a rising edge latches we, dbl, A, wdata; state → ACC_LO; mem_addr ← A, mem_we ← we, mem_wdata ← wdata[DATA-1:0].
- ACC_LO → ACC_HI if dbl (mem_addr ← (A+1) mod 2^ADDR, mem_wdata ← wdata high half, mem_we ← we); else → CAP_LO if load; else → IDLE with rsp_valid pulse.
- ACC_HI: on a load, latch mem_rdata into rsp_rdata[DATA-1:0]; next state → CAP_HI if load, else → IDLE with rsp_valid pulse.
- CAP_LO (single load): latch mem_rdata into rsp_rdata[DATA-1:0], clear upper half; → IDLE, rsp_valid pulse.
- CAP_HI (double load): latch mem_rdata into rsp_rdata[2*DATA-1:DATA]; → IDLE, rsp_valid pulse.
- Leaving ACC_* for CAP_*/IDLE: mem_we ← 0. mem_we is never 1 outside ACC_LO/ACC_HI. mem_addr holds its last value in IDLE; the memory's idle reads are harmless.
- Stores leave rsp_rdata unchanged.
- rsp_err = 1 only for dbl with A = 2^ADDR-1. The access still completes, with the high word at address 0.
- Requests with req_valid low are ignored. Request inputs are don't-care when not accepted.

## Timing
- Latency counts from accept edge E0 to the cycle rsp_valid is high: single store 2, double store 3, single load 3, double load 4.
- rsp_valid is high for exactly one cycle. req_ready is high in that same cycle, so back-to-back accepts are allowed. Throughput is one request per latency.
- The memory write happens at the edge ending each ACC cycle with mem_we = 1.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Reset mid-operation aborts the transfer: no rsp_valid, mem_we 0 from the next cycle. A write presented in the cycle rst is high still completes in memory, because the memory has no reset. A request with rst high is not accepted.

## Test plan
- Reset: hold rst 2 cycles → all outputs at reset values, req_ready = 1, no mem_we pulse.
- Single store then load: store A=0x010, W=0x0000_BEEF → rsp_valid 2 cycles after accept. Then load 0x010 → rsp_valid 3 cycles after accept, rsp_rdata = 0x0000_BEEF, rsp_err = 0.
- Double store/load: store A=0x020, W=0x1234_5678 → mem[0x020]=0x5678, mem[0x021]=0x1234. Load dbl 0x020 → rsp_rdata = 0x1234_5678 at latency 4.
- Wrap: dbl store A=0xFFF, W=0xAAAA_5555 → mem[0xFFF]=0x5555, mem[0x000]=0xAAAA, rsp_err = 1. Follow with a dbl load of 0xFFF → 0xAAAA_5555, rsp_err = 1.
- Back-to-back: req_valid held high with 4 queued requests → each accepted in the rsp_valid cycle of the previous one; mem_we never high in IDLE/CAP states.
- Reset in ACC_HI of a dbl store → low word written, high word written only if rst is in that same cycle, no rsp_valid, req_ready = 1 the next cycle.
